eth_recv: RTL and testbench

Ethernet frame receiver for the 32-bit word stream used by the MAC interface. It is the receive-side counterpart of the frame transmitter and uses the same word layout.
- It validates ARP request/reply frames addressed to the node's own IP and latches the peer MAC/IP for the ARP and transmit logic.
- It writes IPv4/UDP payload words, fragments included, into the 1024-word receive buffer and flags datagram completion.

---
 rtl/eth_recv.sv | 271 +++++++++++++++++++++++++++
 tb/tb_eth_recv.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_recv.sv
`default_nettype none
// ============================================================================
//  Module   : eth_recv
//  Purpose  : Ethernet frame receiver for the 32-bit MAC word stream.
//             Validates ARP request/reply frames aimed at the node's own IP
//             and latches the peer MAC/IP. Writes IPv4/UDP payload words,
//             fragments included, into a 1024-word receive buffer and flags
//             datagram completion.
//  Ports    : clk, rst (async, active-high)
//             i_self_mac/i_self_ip        own addresses
//             i_data/i_vld/i_sop/i_eop    frame word stream in, o_rdy back
//             o_arp_req/o_arp_resp        ARP result pulses, o_peer_mac/ip
//             o_wr_en/o_wr_addr/o_wr_data payload buffer write port
//             o_udp_done/o_udp_len        datagram completion + length
//             o_drop                      frame discarded pulse
//  Revision : 1.0 - initial release
// ============================================================================
module eth_recv #(
    parameter logic [15:0] P_UDP_PORT = 16'd2179
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] i_self_mac,
    input  logic [31:0] i_self_ip,
    input  logic [31:0] i_data,
    input  logic        i_vld,
    input  logic        i_sop,
    input  logic        i_eop,
    output logic        o_rdy,
    output logic        o_arp_req,
    output logic        o_arp_resp,
    output logic [47:0] o_peer_mac,
    output logic [31:0] o_peer_ip,
    output logic        o_wr_en,
    output logic [9:0]  o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic        o_udp_done,
    output logic [15:0] o_udp_len,
    output logic        o_drop
);

    localparam logic [2:0]  S_IDLE    = 3'd0;
    localparam logic [2:0]  S_HDR     = 3'd1;
    localparam logic [2:0]  S_PAYLOAD = 3'd2;
    localparam logic [2:0]  S_DROP    = 3'd3;
    localparam logic [2:0]  S_DONE    = 3'd4;

    localparam logic [15:0] C_ETH_ARP  = 16'h0806;
    localparam logic [15:0] C_ETH_IPV4 = 16'h0800;

    logic [2:0]  r_state, w_state_nxt;
    logic        r_rdy;
    logic [3:0]  r_wcnt;          // header words received so far
    logic [3:0]  w_k;             // index of the word currently presented
    logic        r_da_self, r_da_bcast;
    logic        r_is_arp, r_oper_req, r_mf;
    logic [12:0] r_offset;
    logic [15:0] r_tlen;
    logic [13:0] r_rem;           // payload words still expected
    logic [9:0]  r_addr;
    logic [47:0] r_sha;
    logic [31:0] r_spa;

    logic        r_arp_req, r_arp_resp, r_drop, r_udp_done, r_wr_en;
    logic [47:0] r_peer_mac;
    logic [31:0] r_peer_ip;
    logic [9:0]  r_wr_addr;
    logic [31:0] r_wr_data;
    logic [15:0] r_udp_len;

    logic        w_xfer, w_start, w_hdr_bad;
    logic        w_drop, w_req, w_resp, w_udp_ok, w_wr;

    assign w_xfer  = i_vld && r_rdy;
    assign w_k     = r_wcnt + 4'd1;
    // A sop word always (re)starts a frame, whatever state we were in.
    assign w_start = w_xfer && i_sop && (r_state != S_DONE);

    // Per-word header acceptance checks; word 4 fixes ARP vs IPv4 for later words.
    always_comb begin
        w_hdr_bad = 1'b0;
        case (w_k)
            4'd2:  w_hdr_bad = !((r_da_self  && (i_data == i_self_mac[31:0])) ||
                                 (r_da_bcast && (i_data == 32'hFFFF_FFFF)));
            4'd4:  w_hdr_bad = (i_data[15:0] != C_ETH_ARP) && (i_data[15:0] != C_ETH_IPV4);
            4'd5:  w_hdr_bad = r_is_arp ? (i_data != 32'h0001_0800)
                                        : ((i_data[31:24] != 8'h45) ||
                                           (i_data[15:0] < 16'd28) ||
                                           (i_data[1:0] != 2'b00));
            4'd6:  w_hdr_bad = r_is_arp && ((i_data[31:16] != 16'h0604) ||
                                            ((i_data[15:0] != 16'd1) && (i_data[15:0] != 16'd2)));
            4'd7:  w_hdr_bad = !r_is_arp && (i_data[23:16] != 8'd17);
            4'd9:  w_hdr_bad = !r_is_arp && (i_data != i_self_ip);
            4'd10: w_hdr_bad = !r_is_arp && (i_data[15:0] != P_UDP_PORT);
            4'd11: w_hdr_bad = r_is_arp && (i_data != i_self_ip);
            default: w_hdr_bad = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drop      = 1'b0;
        w_req       = 1'b0;
        w_resp      = 1'b0;
        w_udp_ok    = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer && i_sop) begin
                    if (i_eop) begin
                        w_state_nxt = S_DONE;
                        w_drop      = 1'b1;
                    end else begin
                        w_state_nxt = S_HDR;
                    end
                end
            end
            S_HDR, S_PAYLOAD, S_DROP: begin
                if (w_xfer) begin
                    if (i_sop) begin
                        // Abandon the current frame; the pulse is reported
                        // right away and the word starts the new frame.
                        w_drop      = 1'b1;
                        w_state_nxt = i_eop ? S_DONE : S_HDR;
                    end else if (r_state == S_DROP) begin
                        if (i_eop) begin
                            w_state_nxt = S_DONE;
                            w_drop      = 1'b1;
                        end
                    end else if (r_state == S_HDR) begin
                        if (w_hdr_bad) begin
                            w_state_nxt = i_eop ? S_DONE : S_DROP;
                            w_drop      = i_eop;
                        end else if (w_k == 4'd11) begin
                            if (!i_eop) begin
                                w_state_nxt = S_PAYLOAD;
                            end else begin
                                w_state_nxt = S_DONE;
                                if (r_is_arp) begin
                                    w_req  = r_oper_req;
                                    w_resp = !r_oper_req;
                                end else if (r_rem == 14'd0) begin
                                    w_udp_ok = 1'b1;
                                end else begin
                                    w_drop = 1'b1;
                                end
                            end
                        end else if (i_eop) begin
                            w_state_nxt = S_DONE;
                            w_drop      = 1'b1;
                        end
                    end else begin
                        // PAYLOAD: ARP only swallows pad; UDP counts words.
                        if (r_is_arp) begin
                            if (i_eop) begin
                                w_state_nxt = S_DONE;
                                w_req       = r_oper_req;
                                w_resp      = !r_oper_req;
                            end
                        end else if (r_rem == 14'd0) begin
                            w_state_nxt = i_eop ? S_DONE : S_DROP;
                            w_drop      = i_eop;
                        end else begin
                            w_wr = 1'b1;
                            if (i_eop) begin
                                w_state_nxt = S_DONE;
                                w_udp_ok    = (r_rem == 14'd1);
                                w_drop      = (r_rem != 14'd1);
                            end
                        end
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rdy      <= 1'b0;
            r_wcnt     <= 4'd0;
            r_da_self  <= 1'b0;
            r_da_bcast <= 1'b0;
            r_is_arp   <= 1'b0;
            r_oper_req <= 1'b0;
            r_mf       <= 1'b0;
            r_offset   <= 13'd0;
            r_tlen     <= 16'd0;
            r_rem      <= 14'd0;
            r_addr     <= 10'd0;
            r_sha      <= 48'd0;
            r_spa      <= 32'd0;
            r_arp_req  <= 1'b0;
            r_arp_resp <= 1'b0;
            r_drop     <= 1'b0;
            r_udp_done <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 10'd0;
            r_wr_data  <= 32'd0;
            r_peer_mac <= 48'd0;
            r_peer_ip  <= 32'd0;
            r_udp_len  <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_rdy      <= (w_state_nxt != S_DONE);
            r_arp_req  <= w_req;
            r_arp_resp <= w_resp;
            r_drop     <= w_drop;
            r_udp_done <= w_udp_ok && !r_mf;
            r_wr_en    <= w_wr;

            if (w_wr) begin
                r_wr_addr <= r_addr;
                r_wr_data <= i_data;
                r_addr    <= r_addr + 10'd1;
                r_rem     <= r_rem - 14'd1;
            end
            if (w_req || w_resp) begin
                r_peer_mac <= r_sha;
                r_peer_ip  <= r_spa;
            end
            if (w_udp_ok && !r_mf) begin
                r_udp_len <= {r_offset, 3'b000} + (r_tlen - 16'd28);
            end

            if (w_start) begin
                r_wcnt     <= 4'd1;
                r_da_self  <= (i_data[15:0] == i_self_mac[47:32]);
                r_da_bcast <= (i_data[15:0] == 16'hFFFF);
            end else if (w_xfer && (r_state == S_HDR)) begin
                r_wcnt <= w_k;
                case (w_k)
                    4'd4: r_is_arp <= (i_data[15:0] == C_ETH_ARP);
                    4'd5: begin
                        r_tlen <= i_data[15:0];
                        r_rem  <= i_data[15:2] - 14'd7;   // (TLEN-28)/4
                    end
                    4'd6: begin
                        r_mf       <= i_data[13];
                        r_offset   <= i_data[12:0];
                        r_addr     <= {i_data[8:0], 1'b0}; // 8-byte units -> words
                        r_oper_req <= (i_data[15:0] == 16'd1);
                    end
                    4'd7: r_sha[47:16] <= i_data;
                    4'd8: begin
                        r_sha[15:0]  <= i_data[31:16];
                        r_spa[31:16] <= i_data[15:0];
                    end
                    4'd9: r_spa[15:0] <= i_data[31:16];
                    default: ;
                endcase
            end
        end
    end

    assign o_rdy      = r_rdy;
    assign o_arp_req  = r_arp_req;
    assign o_arp_resp = r_arp_resp;
    assign o_peer_mac = r_peer_mac;
    assign o_peer_ip  = r_peer_ip;
    assign o_wr_en    = r_wr_en;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_udp_done = r_udp_done;
    assign o_udp_len  = r_udp_len;
    assign o_drop     = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_eth_recv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_recv
//  Purpose  : Directed self-checking bench for eth_recv.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_eth_recv;

    localparam logic [47:0] C_SELF_MAC = 48'h0200_0000_0001;
    localparam logic [31:0] C_SELF_IP  = 32'hC0A8_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_data;
    logic        i_vld, i_sop, i_eop;
    logic        o_rdy, o_arp_req, o_arp_resp, o_wr_en, o_udp_done, o_drop;
    logic [47:0] o_peer_mac;
    logic [31:0] o_peer_ip, o_wr_data;
    logic [9:0]  o_wr_addr;
    logic [15:0] o_udp_len;

    always #5 clk = ~clk;

    eth_recv #(.P_UDP_PORT(16'd2179)) dut (
        .clk(clk), .rst(rst),
        .i_self_mac(C_SELF_MAC), .i_self_ip(C_SELF_IP),
        .i_data(i_data), .i_vld(i_vld), .i_sop(i_sop), .i_eop(i_eop),
        .o_rdy(o_rdy), .o_arp_req(o_arp_req), .o_arp_resp(o_arp_resp),
        .o_peer_mac(o_peer_mac), .o_peer_ip(o_peer_ip),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_udp_done(o_udp_done), .o_udp_len(o_udp_len), .o_drop(o_drop)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] fw [1:400];

    // Passive capture of writes and pulses (sampled mid-cycle).
    int          wr_n   = 0;
    int          n_drop = 0;
    int          n_req  = 0;
    int          n_resp = 0;
    int          n_done = 0;
    logic [9:0]  wr_a [0:1023];
    logic [31:0] wr_d [0:1023];

    always @(negedge clk) begin
        if (o_wr_en) begin
            if (wr_n < 1024) begin
                wr_a[wr_n] = o_wr_addr;
                wr_d[wr_n] = o_wr_data;
            end
            wr_n++;
        end
        if (o_drop)     n_drop++;
        if (o_arp_req)  n_req++;
        if (o_arp_resp) n_resp++;
        if (o_udp_done) n_done++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word and return #1 after the edge that transfers it.
    task automatic send(input logic [31:0] d, input logic s, input logic e);
        int w = 0;
        @(negedge clk);
        i_data = d; i_vld = 1'b1; i_sop = s; i_eop = e;
        while (!o_rdy && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!o_rdy) check("rdy_timeout", {63'd0, o_rdy}, 64'd1);
        @(posedge clk);
        #1;
        i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    endtask

    task automatic send_frame(input int n);
        for (int k = 1; k <= n; k++) send(fw[k], k == 1, k == n);
    endtask

    task automatic build_arp(input logic [47:0] da, input logic [15:0] oper,
                             input logic [47:0] sha, input logic [31:0] spa,
                             input logic [31:0] tpa);
        fw[1]  = {16'h0000, da[47:32]};
        fw[2]  = da[31:0];
        fw[3]  = sha[47:16];
        fw[4]  = {sha[15:0], 16'h0806};
        fw[5]  = 32'h0001_0800;
        fw[6]  = {16'h0604, oper};
        fw[7]  = sha[47:16];
        fw[8]  = {sha[15:0], spa[31:16]};
        fw[9]  = {spa[15:0], 16'h0000};
        fw[10] = 32'h0000_0000;
        fw[11] = tpa;
    endtask

    task automatic build_udp(input logic [15:0] tlen, input logic mf, input logic [12:0] off,
                             input logic [31:0] base, input logic [31:0] step);
        int n;
        n = (int'(tlen) - 28) / 4;
        fw[1]  = {16'h0000, C_SELF_MAC[47:32]};
        fw[2]  = C_SELF_MAC[31:0];
        fw[3]  = 32'h0200_0000;
        fw[4]  = {16'h0002, 16'h0800};
        fw[5]  = {8'h45, 8'h00, tlen};
        fw[6]  = {16'h1234, 2'b00, mf, off};
        fw[7]  = {8'h40, 8'd17, 16'h0000};
        fw[8]  = 32'hC0A8_0002;
        fw[9]  = C_SELF_IP;
        fw[10] = {16'h1000, 16'd2179};
        fw[11] = {tlen - 16'd20, 16'h0000};
        for (int j = 0; j < n; j++) fw[12 + j] = base + step * j;
    endtask

    initial begin
        int base;
        int drop0;
        rst = 1'b1; i_data = 32'd0; i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy",      {63'd0, o_rdy},     64'd0);
        check("rst_drop",     {63'd0, o_drop},    64'd0);
        check("rst_wr_en",    {63'd0, o_wr_en},   64'd0);
        check("rst_peer_mac", {16'd0, o_peer_mac}, 64'd0);
        check("rst_udp_len",  {48'd0, o_udp_len}, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("rdy_after_rst", {63'd0, o_rdy}, 64'd1);

        // ---------------- ARP request for own IP ----------------
        build_arp(48'hFFFF_FFFF_FFFF, 16'd1, 48'h0200_0000_0002, 32'hC0A8_0002, C_SELF_IP);
        send_frame(11);
        check("arp_req_pulse", {63'd0, o_arp_req}, 64'd1);
        check("arp_done_rdy",  {63'd0, o_rdy},     64'd0);
        check("arp_peer_mac",  {16'd0, o_peer_mac}, 64'h0000_0200_0000_0002);
        check("arp_peer_ip",   {32'd0, o_peer_ip},  64'hC0A8_0002);
        @(posedge clk); #1;
        check("arp_req_1cyc",  {63'd0, o_arp_req}, 64'd0);
        check("arp_rdy_back",  {63'd0, o_rdy},     64'd1);

        // ---------------- ARP for foreign IP ----------------
        build_arp(48'hFFFF_FFFF_FFFF, 16'd1, 48'h0200_0000_0005, 32'hC0A8_0005, 32'hC0A8_0009);
        send_frame(11);
        check("arp_bad_drop",  {63'd0, o_drop},    64'd1);
        check("arp_bad_noreq", {63'd0, o_arp_req}, 64'd0);
        check("arp_bad_mac",   {16'd0, o_peer_mac}, 64'h0000_0200_0000_0002);
        check("arp_bad_ip",    {32'd0, o_peer_ip},  64'hC0A8_0002);

        // ---------------- UDP, 4 payload words ----------------
        base = wr_n;
        build_udp(16'd44, 1'b0, 13'd0, 32'h1111_1111, 32'h1111_1111);
        send_frame(15);
        check("udp_done",      {63'd0, o_udp_done}, 64'd1);
        check("udp_len",       {48'd0, o_udp_len},  64'd16);
        check("udp_last_wr",   {63'd0, o_wr_en},    64'd1);
        check("udp_last_addr", {54'd0, o_wr_addr},  64'd3);
        check("udp_last_data", {32'd0, o_wr_data},  64'h4444_4444);
        @(posedge clk); #1;
        check("udp_wr_count", 64'(wr_n - base), 64'd4);
        for (int j = 0; j < 4; j++) begin
            check("udp_addr", {54'd0, wr_a[base + j]}, 64'(j));
            check("udp_data", {32'd0, wr_d[base + j]}, 64'(32'h1111_1111 * (j + 1)));
        end

        // ---------------- two fragments ----------------
        base = wr_n;
        build_udp(16'd1428, 1'b1, 13'd0, 32'hA000_0000, 32'd1);
        send_frame(11 + 350);
        check("frag1_nodone", {63'd0, o_udp_done}, 64'd0);
        check("frag1_nodrop", {63'd0, o_drop},     64'd0);
        @(posedge clk); #1;
        check("frag1_count", 64'(wr_n - base), 64'd350);
        check("frag1_first", {54'd0, wr_a[base]},       64'd0);
        check("frag1_last",  {54'd0, wr_a[base + 349]}, 64'd349);
        check("frag1_ldata", {32'd0, wr_d[base + 349]}, 64'hA000_015D);
        base = wr_n;
        build_udp(16'd128, 1'b0, 13'd175, 32'hB000_0000, 32'd1);
        send_frame(11 + 25);
        check("frag2_done", {63'd0, o_udp_done}, 64'd1);
        check("frag2_len",  {48'd0, o_udp_len},  64'd1500);
        @(posedge clk); #1;
        check("frag2_count", 64'(wr_n - base), 64'd25);
        check("frag2_first", {54'd0, wr_a[base]},      64'd350);
        check("frag2_last",  {54'd0, wr_a[base + 24]}, 64'd374);

        // ---------------- UDP with early eop ----------------
        base = wr_n;
        build_udp(16'd44, 1'b0, 13'd0, 32'hC000_0000, 32'd1);
        send_frame(13);
        check("early_drop",   {63'd0, o_drop},     64'd1);
        check("early_nodone", {63'd0, o_udp_done}, 64'd0);
        @(posedge clk); #1;
        check("early_count", 64'(wr_n - base), 64'd2);
        check("early_addr1", {54'd0, wr_a[base + 1]}, 64'd1);

        // ---------------- sop mid-frame, then ARP reply ----------------
        drop0 = n_drop;
        build_arp(48'hFFFF_FFFF_FFFF, 16'd1, 48'h0200_0000_0007, 32'hC0A8_0007, C_SELF_IP);
        for (int k = 1; k <= 6; k++) send(fw[k], k == 1, 1'b0);
        build_arp(C_SELF_MAC, 16'd2, 48'h0200_0000_0003, 32'hC0A8_0003, C_SELF_IP);
        send(fw[1], 1'b1, 1'b0);
        check("sop_mid_drop", {63'd0, o_drop}, 64'd1);
        for (int k = 2; k <= 11; k++) send(fw[k], 1'b0, k == 11);
        check("resp_pulse", {63'd0, o_arp_resp}, 64'd1);
        check("resp_noreq", {63'd0, o_arp_req},  64'd0);
        check("resp_mac",   {16'd0, o_peer_mac}, 64'h0000_0200_0000_0003);
        check("resp_ip",    {32'd0, o_peer_ip},  64'hC0A8_0003);
        @(posedge clk); #1;
        check("sop_mid_drop_cnt", 64'(n_drop - drop0), 64'd1);

        // ---------------- reset mid-frame ----------------
        build_arp(48'hFFFF_FFFF_FFFF, 16'd1, 48'h0200_0000_0002, 32'hC0A8_0002, C_SELF_IP);
        for (int k = 1; k <= 5; k++) send(fw[k], k == 1, 1'b0);
        @(negedge clk); rst = 1'b1;
        #1;
        check("mrst_rdy",     {63'd0, o_rdy},      64'd0);
        check("mrst_mac",     {16'd0, o_peer_mac}, 64'd0);
        check("mrst_ip",      {32'd0, o_peer_ip},  64'd0);
        check("mrst_wr_addr", {54'd0, o_wr_addr},  64'd0);
        check("mrst_udp_len", {48'd0, o_udp_len},  64'd0);
        @(negedge clk); rst = 1'b0;
        drop0 = n_drop;
        for (int k = 6; k <= 11; k++) send(fw[k], 1'b0, k == 11);
        @(posedge clk); #1;
        check("mrst_ignored", 64'(n_drop - drop0), 64'd0);
        check("mrst_noreq",   {63'd0, o_arp_req},  64'd0);
        send_frame(11);
        check("mrst_arp_req", {63'd0, o_arp_req},  64'd1);
        check("mrst_arp_mac", {16'd0, o_peer_mac}, 64'h0000_0200_0000_0002);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
